// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// State and ALU function encodings, opcode/func constants, decoder result type.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF     = 4'd0,
    ST_ID     = 4'd1,
    ST_EXE_R  = 4'd2,
    ST_EXE_I  = 4'd3,
    ST_EXE_LS = 4'd4,
    ST_EXE_BR = 4'd5,
    ST_EXE_J  = 4'd6,
    ST_EXE_JR = 4'd7,
    ST_MEM    = 4'd8,
    ST_WB_ALU = 4'd9,
    ST_WB_LD  = 4'd10,
    ST_HALT   = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_R    = 3'd1,
    CLS_JR   = 3'd2,
    CLS_I    = 3'd3,
    CLS_LS   = 3'd4,
    CLS_BR   = 3'd5,
    CLS_J    = 3'd6,
    CLS_HALT = 3'd7
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    alu_op_e    alu_op;
    logic       ext_sel;
    logic       alu_src_a;
    logic       illegal;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Shifts take their A operand from the shamt field rather than rs.
  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-side inputs and datapath control outputs of the sequencer.
// master = sequencer, slave = datapath.
interface mc_ctrl_fsm_if #(
  parameter int STATE_W = 4
) ();

  logic [5:0]         Opcode;
  logic [5:0]         func;
  logic               Zero;
  logic               mem_ready;
  logic               PCWre;
  logic               IRWre;
  logic               memRd;
  logic               memWt;
  logic               IorD;
  logic               RegWre;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               ALUSrc_A;
  logic [1:0]         ALUSrc_B;
  logic               ExtSel;
  logic [3:0]         ALUOp;
  logic [1:0]         PCSrc;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  Opcode, func, Zero, mem_ready,
    output PCWre, IRWre, memRd, memWt, IorD, RegWre, RegDst, MemtoReg,
           ALUSrc_A, ALUSrc_B, ExtSel, ALUOp, PCSrc, illegal, state
  );

  modport slave (
    output Opcode, func, Zero, mem_ready,
    input  PCWre, IRWre, memRd, memWt, IorD, RegWre, RegDst, MemtoReg,
           ALUSrc_A, ALUSrc_B, ExtSel, ALUOp, PCSrc, illegal, state
  );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction decode: Opcode/func -> class, ALU function,
// extension mode, ALU A source and illegal flag.
module mc_instr_decode
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.ext_sel = 1'b1;
    if (opcode == HALT_OP) begin
      dec.cls = CLS_HALT;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          dec.cls       = CLS_R;
          dec.alu_src_a = is_shift(func);
          case (func)
            FN_ADD:  dec.alu_op = ALU_ADD;
            FN_SUB:  dec.alu_op = ALU_SUB;
            FN_AND:  dec.alu_op = ALU_AND;
            FN_OR:   dec.alu_op = ALU_OR;
            FN_XOR:  dec.alu_op = ALU_XOR;
            FN_NOR:  dec.alu_op = ALU_NOR;
            FN_SLT:  dec.alu_op = ALU_SLT;
            FN_SLL:  dec.alu_op = ALU_SLL;
            FN_SRL:  dec.alu_op = ALU_SRL;
            FN_SRA:  dec.alu_op = ALU_SRA;
            FN_JR:   dec.cls    = CLS_JR;
            default: begin
              dec.cls     = CLS_NOP;
              dec.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin dec.cls = CLS_I; dec.alu_op = ALU_ADD; end
        OP_SLTI: begin dec.cls = CLS_I; dec.alu_op = ALU_SLT; end
        OP_ANDI: begin dec.cls = CLS_I; dec.alu_op = ALU_AND; dec.ext_sel = 1'b0; end
        OP_ORI:  begin dec.cls = CLS_I; dec.alu_op = ALU_OR;  dec.ext_sel = 1'b0; end
        OP_XORI: begin dec.cls = CLS_I; dec.alu_op = ALU_XOR; dec.ext_sel = 1'b0; end
        OP_LUI:  begin dec.cls = CLS_I; dec.alu_op = ALU_LUI; end
        OP_LW, OP_SW:   dec.cls = CLS_LS;
        OP_BEQ, OP_BNE: begin dec.cls = CLS_BR; dec.alu_op = ALU_SUB; end
        OP_J, OP_JAL:   dec.cls = CLS_J;
        default:        dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer sharing one ALU and one memory port.
// Optional perf counters (cycle_cnt, instr_cnt) built when MC_PERF_CNT_EN is defined.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         STATE_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_fsm_if.master bus
`ifdef MC_PERF_CNT_EN
  , output logic [31:0] cycle_cnt
  , output logic [31:0] instr_cnt
`endif
);

  // state     | meaning
  // IF        | fetch, wait for mem_ready, load IR, PC += 4
  // ID        | decode live Opcode/func, latch them
  // EXE_R/I   | ALU op for R-type / immediate
  // EXE_LS    | address = rs + sign-ext imm
  // EXE_BR    | compare, conditional PC write
  // EXE_J/JR  | jump (jal links $31) / jump register
  // MEM       | data access, wait for mem_ready
  // WB_ALU/LD | register write-back of ALUOut / MDR
  // HALT      | parked until reset

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] func_q, func_d;
  dec_t       dec;
  logic [5:0] dec_op, dec_func;

  logic       pc_wre, ir_wre, mem_rd, mem_wt, i_or_d, reg_wre;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       alu_src_a, ext_sel, illegal;
  alu_op_e    alu_op;

  logic is_lw, is_beq, is_bne, is_jal;

  // ID decodes straight from the IR; later states use the latched copy.
  assign dec_op   = (state_q == ST_ID) ? bus.Opcode : op_q;
  assign dec_func = (state_q == ST_ID) ? bus.func   : func_q;

  mc_instr_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode (dec_op),
    .func   (dec_func),
    .dec    (dec)
  );

  assign is_lw  = (op_q == OP_LW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_bne = (op_q == OP_BNE);
  assign is_jal = (op_q == OP_JAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IF;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    func_d     = func_q;
    pc_wre     = 1'b0;
    ir_wre     = 1'b0;
    mem_rd     = 1'b0;
    mem_wt     = 1'b0;
    i_or_d     = 1'b0;
    reg_wre    = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_sel    = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_wre  = 1'b1;
          pc_wre  = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        op_d    = bus.Opcode;
        func_d  = bus.func;
        illegal = dec.illegal;
        case (dec.cls)
          CLS_R:    state_d = ST_EXE_R;
          CLS_JR:   state_d = ST_EXE_JR;
          CLS_I:    state_d = ST_EXE_I;
          CLS_LS:   state_d = ST_EXE_LS;
          CLS_BR:   state_d = ST_EXE_BR;
          CLS_J:    state_d = ST_EXE_J;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_IF;
        endcase
      end
      ST_EXE_R: begin
        alu_op    = dec.alu_op;
        alu_src_a = dec.alu_src_a;
        reg_dst   = 2'd1;
        state_d   = ST_WB_ALU;
      end
      ST_EXE_I: begin
        alu_op    = dec.alu_op;
        alu_src_b = 2'd1;
        ext_sel   = dec.ext_sel;
        state_d   = ST_WB_ALU;
      end
      ST_EXE_LS: begin
        alu_op    = ALU_ADD;
        alu_src_b = 2'd1;
        ext_sel   = 1'b1;
        state_d   = ST_MEM;
      end
      ST_MEM: begin
        i_or_d = 1'b1;
        mem_rd = is_lw;
        mem_wt = !is_lw;
        if (bus.mem_ready) state_d = is_lw ? ST_WB_LD : ST_IF;
      end
      ST_WB_ALU: begin
        reg_wre = 1'b1;
        reg_dst = (dec.cls == CLS_R) ? 2'd1 : 2'd0;
        state_d = ST_IF;
      end
      ST_WB_LD: begin
        reg_wre    = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = ST_IF;
      end
      ST_EXE_BR: begin
        alu_op  = ALU_SUB;
        pc_src  = 2'd1;
        pc_wre  = (is_beq & bus.Zero) | (is_bne & ~bus.Zero);
        state_d = ST_IF;
      end
      ST_EXE_J: begin
        pc_wre = 1'b1;
        pc_src = 2'd2;
        if (is_jal) begin
          reg_wre    = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = ST_IF;
      end
      ST_EXE_JR: begin
        pc_wre  = 1'b1;
        pc_src  = 2'd3;
        state_d = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // Reset also gates the outputs so IF's fetch strobe is not seen during reset.
  assign bus.PCWre    = rst & pc_wre;
  assign bus.IRWre    = rst & ir_wre;
  assign bus.memRd    = rst & mem_rd;
  assign bus.memWt    = rst & mem_wt;
  assign bus.IorD     = rst & i_or_d;
  assign bus.RegWre   = rst & reg_wre;
  assign bus.RegDst   = rst ? reg_dst    : 2'd0;
  assign bus.MemtoReg = rst ? mem_to_reg : 2'd0;
  assign bus.ALUSrc_A = rst & alu_src_a;
  assign bus.ALUSrc_B = rst ? alu_src_b  : 2'd0;
  assign bus.ExtSel   = rst & ext_sel;
  assign bus.ALUOp    = rst ? 4'(alu_op) : 4'd0;
  assign bus.PCSrc    = rst ? pc_src     : 2'd0;
  assign bus.illegal  = rst & illegal;
  assign bus.state    = STATE_W'(state_q);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        instr_done;

  // An instruction retires when it leaves a post-fetch state for IF or HALT.
  assign instr_done = (state_q != ST_IF) && (state_q != ST_HALT) &&
                      ((state_d == ST_IF) || (state_d == ST_HALT));

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != ST_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (instr_done)         instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction expected control traces
// are queued by the stimulus and compared each cycle by an independent monitor.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.STATE_W(4)) bus ();

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_ctrl_fsm #(.HALT_OP(6'h3F), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt (cycle_cnt)
    , .instr_cnt (instr_cnt)
`endif
  );

  typedef enum int {K_R, K_SH, K_JR, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_HALT, K_ILL} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_e      kind;
    logic [3:0] alu;
    logic       ext;
  } ins_t;

  typedef struct packed {
    logic       pcwre, irwre, memrd, memwt, iord, regwre;
    logic [1:0] regdst, memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    logic mr;
    logic z;
    ctl_t exp;
  } cyc_t;

  ins_t tbl[$];
  cyc_t plan[$];
  ctl_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                              input logic [3:0] alu, input logic ext);
    ins_t e;
    e.op = op; e.fn = fn; e.kind = k; e.alu = alu; e.ext = ext;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t z_ctl(input state_e s);
    ctl_t c;
    c    = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pcwre    = bus.PCWre;
    c.irwre    = bus.IRWre;
    c.memrd    = bus.memRd;
    c.memwt    = bus.memWt;
    c.iord     = bus.IorD;
    c.regwre   = bus.RegWre;
    c.regdst   = bus.RegDst;
    c.memtoreg = bus.MemtoReg;
    c.srca     = bus.ALUSrc_A;
    c.srcb     = bus.ALUSrc_B;
    c.ext      = bus.ExtSel;
    c.aluop    = bus.ALUOp;
    c.pcsrc    = bus.PCSrc;
    c.ill      = bus.illegal;
    c.st       = bus.state;
    return c;
  endfunction

  task automatic push(input logic mr, input logic z, input ctl_t c);
    cyc_t y;
    y.mr = mr; y.z = z; y.exp = c;
    plan.push_back(y);
  endtask

  // Reference: one instruction's cycle-by-cycle control trace from the ISA rules.
  task automatic build(input ins_t e, input logic zero, input int wif, input int wmem);
    ctl_t c;
    for (int i = 0; i < wif; i++) begin
      c = z_ctl(ST_IF); c.memrd = 1'b1; push(1'b0, rb(), c);
    end
    c = z_ctl(ST_IF); c.memrd = 1'b1; c.irwre = 1'b1; c.pcwre = 1'b1; push(1'b1, rb(), c);
    c = z_ctl(ST_ID); c.ill = (e.kind == K_ILL); push(rb(), rb(), c);
    case (e.kind)
      K_R, K_SH: begin
        c = z_ctl(ST_EXE_R); c.aluop = e.alu; c.srca = (e.kind == K_SH); c.regdst = 2'd1;
        push(rb(), rb(), c);
        c = z_ctl(ST_WB_ALU); c.regwre = 1'b1; c.regdst = 2'd1; push(rb(), rb(), c);
      end
      K_I: begin
        c = z_ctl(ST_EXE_I); c.aluop = e.alu; c.srcb = 2'd1; c.ext = e.ext; push(rb(), rb(), c);
        c = z_ctl(ST_WB_ALU); c.regwre = 1'b1; push(rb(), rb(), c);
      end
      K_LW, K_SW: begin
        c = z_ctl(ST_EXE_LS); c.aluop = ALU_ADD; c.srcb = 2'd1; c.ext = 1'b1; push(rb(), rb(), c);
        c = z_ctl(ST_MEM); c.iord = 1'b1; c.memrd = (e.kind == K_LW); c.memwt = (e.kind == K_SW);
        for (int i = 0; i < wmem; i++) push(1'b0, rb(), c);
        push(1'b1, rb(), c);
        if (e.kind == K_LW) begin
          c = z_ctl(ST_WB_LD); c.regwre = 1'b1; c.memtoreg = 2'd1; push(rb(), rb(), c);
        end
      end
      K_BEQ, K_BNE: begin
        c = z_ctl(ST_EXE_BR); c.aluop = ALU_SUB; c.pcsrc = 2'd1;
        c.pcwre = (e.kind == K_BEQ) ? zero : !zero;
        push(rb(), zero, c);
      end
      K_J, K_JAL: begin
        c = z_ctl(ST_EXE_J); c.pcwre = 1'b1; c.pcsrc = 2'd2;
        if (e.kind == K_JAL) begin c.regwre = 1'b1; c.regdst = 2'd2; c.memtoreg = 2'd2; end
        push(rb(), rb(), c);
      end
      K_JR: begin
        c = z_ctl(ST_EXE_JR); c.pcwre = 1'b1; c.pcsrc = 2'd3; push(rb(), rb(), c);
      end
      K_HALT: begin
        for (int i = 0; i < 4; i++) push(rb(), rb(), z_ctl(ST_HALT));
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the last planned cycle.
  task automatic play(input ins_t e);
    cyc_t y;
    while (plan.size() > 0) begin
      y = plan.pop_front();
      bus.Opcode    = e.op;
      bus.func      = e.fn;
      bus.mem_ready = y.mr;
      bus.Zero      = y.z;
      exp_q.push_back(y.exp);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    ctl_t a, e;
    if (mon_en && rst && exp_q.size() > 0) begin
      a = sample();
      e = exp_q.pop_front();
      chk($sformatf("ctl(st=%0d)", e.st), 32'(a), 32'(e));
      chk("one_strobe", 32'(a.memrd & a.memwt), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t e;
    int   idx;
    bus.Opcode = '0; bus.func = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    tbl.push_back(mk(6'h00, 6'h20, K_R,   ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h00, 6'h22, K_R,   ALU_SUB, 1'b0));
    tbl.push_back(mk(6'h00, 6'h24, K_R,   ALU_AND, 1'b0));
    tbl.push_back(mk(6'h00, 6'h25, K_R,   ALU_OR,  1'b0));
    tbl.push_back(mk(6'h00, 6'h26, K_R,   ALU_XOR, 1'b0));
    tbl.push_back(mk(6'h00, 6'h27, K_R,   ALU_NOR, 1'b0));
    tbl.push_back(mk(6'h00, 6'h2A, K_R,   ALU_SLT, 1'b0));
    tbl.push_back(mk(6'h00, 6'h00, K_SH,  ALU_SLL, 1'b0));
    tbl.push_back(mk(6'h00, 6'h02, K_SH,  ALU_SRL, 1'b0));
    tbl.push_back(mk(6'h00, 6'h03, K_SH,  ALU_SRA, 1'b0));
    tbl.push_back(mk(6'h00, 6'h08, K_JR,  ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h00, 6'h01, K_ILL, ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h08, 6'h00, K_I,   ALU_ADD, 1'b1));
    tbl.push_back(mk(6'h0A, 6'h00, K_I,   ALU_SLT, 1'b1));
    tbl.push_back(mk(6'h0C, 6'h00, K_I,   ALU_AND, 1'b0));
    tbl.push_back(mk(6'h0D, 6'h00, K_I,   ALU_OR,  1'b0));
    tbl.push_back(mk(6'h0E, 6'h00, K_I,   ALU_XOR, 1'b0));
    tbl.push_back(mk(6'h0F, 6'h00, K_I,   ALU_LUI, 1'b1));
    tbl.push_back(mk(6'h23, 6'h00, K_LW,  ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h2B, 6'h00, K_SW,  ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h04, 6'h00, K_BEQ, ALU_SUB, 1'b0));
    tbl.push_back(mk(6'h05, 6'h00, K_BNE, ALU_SUB, 1'b0));
    tbl.push_back(mk(6'h02, 6'h00, K_J,   ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h03, 6'h00, K_JAL, ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h3E, 6'h00, K_ILL, ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h01, 6'h00, K_ILL, ALU_ADD, 1'b0));
    tbl.push_back(mk(6'h3F, 6'h00, K_HALT, ALU_ADD, 1'b0));

    #1;
    chk("reset_outputs", 32'(sample()), 32'(z_ctl(ST_IF)));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed: add, lw with 2 MEM waits, beq taken/not taken, jal, illegal 0x3E
    build(tbl[0], 1'b0, 0, 0);                     play(tbl[0]);
    build(tbl[18], 1'b0, 0, 2);                    play(tbl[18]);
    build(tbl[20], 1'b1, 0, 0);                    play(tbl[20]);
    build(tbl[20], 1'b0, 0, 0);                    play(tbl[20]);
    build(tbl[23], 1'b0, 0, 0);                    play(tbl[23]);
    build(tbl[24], 1'b0, 0, 0);                    play(tbl[24]);

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, tbl.size() - 2);
      e = tbl[idx];
      if (e.op != 6'h00) e.fn = 6'($urandom_range(0, 63));
      build(e, rb(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      play(e);
    end

    // Asynchronous reset in the middle of a stalled store
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    bus.Opcode = OP_SW; bus.func = 6'h00; bus.mem_ready = 1'b1; bus.Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    chk("mem_state", 32'(bus.state), 32'(ST_MEM));
    chk("memwt_in_mem", 32'(bus.memWt), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("memwt_async_drop", 32'(bus.memWt), 32'd0);
    chk("reset_mid_mem", 32'(sample()), 32'(z_ctl(ST_IF)));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // HALT parks the FSM; reset mid-HALT brings it back to IF
    build(tbl[tbl.size() - 1], 1'b0, 1, 0);
    play(tbl[tbl.size() - 1]);
    chk("exp_q_drained_halt", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    chk("halt_state", 32'(bus.state), 32'(ST_HALT));
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_halt", 32'(sample()), 32'(z_ctl(ST_IF)));
`ifdef MC_PERF_CNT_EN
    chk("cycle_cnt_reset", cycle_cnt, 32'd0);
    chk("instr_cnt_reset", instr_cnt, 32'd0);
`endif
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
